// File: rtl/dev_timer_pkg.sv
// Shared definitions for dev_timer: register offsets, CTRL layout, MODE codes, FSM encoding.
// The PRESCALE offset only exists when TIMER_PRESCALE_EN is defined.
package dev_timer_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_PRESET   = 8'h04;
  localparam logic [7:0] ADDR_COUNT    = 8'h08;
`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] ADDR_PRESCALE = 8'h0C;
`endif

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_PEND_BIT = 4;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Field order matches the CTRL bit positions above (pend is bit 4, en is bit 0).
  typedef struct packed {
    logic       pend;
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {27'd0, c};
  endfunction

endpackage

// File: rtl/dev_timer_if.sv
// Register bus between a host and dev_timer: combinational read data, edge-sampled write strobe.
interface dev_timer_if;
  logic [31:0] dev_out;
  logic [31:0] dev_in;
  logic [7:0]  dev_addr;
  logic        we;

  modport master (input dev_out, output dev_in, output dev_addr, output we);
  modport slave  (output dev_out, input dev_in, input dev_addr, input we);
endinterface

// File: rtl/dev_timer_prescaler.sv
// timer_prescaler: divides count steps to one every prescale+1 cycles while running.
// Latency: tick is combinational from the divider state; restart zeroes the divider on the next edge.
// Backpressure: none; built only when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        run,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] div;

  // >= keeps the divider from running away if prescale is lowered mid-count.
  assign tick = (div >= prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= 16'd0;
    end else if (restart) begin
      div <= 16'd0;
    end else if (run) begin
      div <= tick ? 16'd0 : div + 16'd1;
    end
  end

endmodule

// File: rtl/dev_timer.sv
// dev_timer: memory-mapped down-counter with one-shot/auto-reload modes and a masked interrupt.
// Latency: reads are combinational, writes land on the sampling edge; irq is registered.
// Backpressure: none. Define TIMER_PRESCALE_EN to add the PRESCALE register at 0x0C.
module dev_timer #(
  parameter logic [31:0] UNMAPPED_VAL = 32'hdead_beef
) (
  input  logic        clk,
  input  logic        rst,
  dev_timer_if.slave  bus,
  output logic        irq
);
  import dev_timer_pkg::*;

  state_t      state, state_next;
  ctrl_t       ctrl, ctrl_next;
  logic [31:0] preset;
  logic [31:0] count, count_next;
  logic        pend_set;
  logic        en_hw_clr;
  logic        tick;
  logic        wr_ctrl;
  logic        wr_preset;

  assign wr_ctrl   = bus.we && (bus.dev_addr == ADDR_CTRL);
  assign wr_preset = bus.we && (bus.dev_addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic        wr_prescale;

  assign wr_prescale = bus.we && (bus.dev_addr == ADDR_PRESCALE);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= 16'd0;
    end else if (wr_prescale) begin
      prescale <= bus.dev_in[15:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .restart  (state == ST_LOAD),
    .run      (state == ST_CNT),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    bus.dev_out = UNMAPPED_VAL;
    case (bus.dev_addr)
      ADDR_CTRL:     bus.dev_out = ctrl_word(ctrl);
      ADDR_PRESET:   bus.dev_out = preset;
      ADDR_COUNT:    bus.dev_out = count;
`ifdef TIMER_PRESCALE_EN
      ADDR_PRESCALE: bus.dev_out = {16'd0, prescale};
`endif
      default:       bus.dev_out = UNMAPPED_VAL;
    endcase
  end

  // Losing EN in any active state parks the FSM in IDLE with COUNT frozen.
  always_comb begin
    state_next = state;
    count_next = count;
    pend_set   = 1'b0;
    en_hw_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl.en) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (!ctrl.en) begin
          state_next = ST_IDLE;
        end else begin
          count_next = preset;
          state_next = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!ctrl.en) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (count > 32'd1) begin
            count_next = count - 32'd1;
          end else begin
            count_next = 32'd0;
            state_next = ST_DONE;
            pend_set   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!ctrl.en) begin
          state_next = ST_IDLE;
        end else if (ctrl.mode == MODE_AUTO) begin
          state_next = ST_LOAD;
        end else begin
          en_hw_clr  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Software EN beats the one-shot hardware clear; a fresh PEND beats a software clear.
  always_comb begin
    ctrl_next = ctrl;
    if (wr_ctrl) begin
      ctrl_next.en   = bus.dev_in[CTRL_EN_BIT];
      ctrl_next.mode = bus.dev_in[CTRL_MODE_MSB:CTRL_MODE_LSB];
      ctrl_next.im   = bus.dev_in[CTRL_IM_BIT];
    end else if (en_hw_clr) begin
      ctrl_next.en = 1'b0;
    end
    ctrl_next.pend = pend_set | (ctrl.pend & ~wr_ctrl);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ctrl   <= '0;
      preset <= 32'd0;
      count  <= 32'd0;
      irq    <= 1'b0;
    end else begin
      state <= state_next;
      ctrl  <= ctrl_next;
      count <= count_next;
      irq   <= ctrl_next.pend & ctrl_next.im;
      if (wr_preset) preset <= bus.dev_in;
    end
  end

endmodule
